// File: rtl/adr_pwrfail_detect.sv
// adr_pwrfail_detect: PWROK/SLP_S3# conditioning, surprise power-loss detect and ADR handshake watchdog
module adr_pwrfail_detect #(
  parameter int FILTER_CNT  = 4,
  parameter int TIMEOUT_CNT = 200
) (
  input  logic iClk,
  input  logic iRst_n,
  input  logic iAdrEna,
  input  logic iPwrGdPsuRaw,
  input  logic iFmSlp3Pld_n,
  input  logic iFmAdrComplete,
  input  logic iFmAdrAck_n,
  output logic oPwrGdPsuFilt,
  output logic oAdrEvent,
  output logic oAdrDone,
  output logic oAdrTimeout,
  output logic oAdrBusy
);
  localparam int FW = $clog2(FILTER_CNT + 1);
  localparam int TW = $clog2(TIMEOUT_CNT + 1);
  typedef enum logic [2:0] {DISARMED, ARMED, EVENT, WAIT_ACK, DONE, TIMEOUT} state_t;
  state_t state, stateNext;
  logic [1:0] pwrSync, slpSync;
  logic [FW-1:0] filtCnt;
  logic [TW-1:0] tCnt;
  logic pwrFiltQ, pwrFall, slpOk, tExpire, busyNext;
  assign slpOk    = slpSync[1];
  assign pwrFall  = pwrFiltQ & ~oPwrGdPsuFilt;
  assign tExpire  = tCnt == TW'(TIMEOUT_CNT - 1);
  assign busyNext = (stateNext == EVENT) || (stateNext == WAIT_ACK);
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      pwrSync       <= '0;
      slpSync       <= '0;
      pwrFiltQ      <= 1'b0;
      oPwrGdPsuFilt <= 1'b0;
      filtCnt       <= '0;
    end else begin
      pwrSync  <= {pwrSync[0], iPwrGdPsuRaw};
      slpSync  <= {slpSync[0], iFmSlp3Pld_n};
      pwrFiltQ <= oPwrGdPsuFilt;
      if (pwrSync[1] == oPwrGdPsuFilt) filtCnt <= '0;
      else if (filtCnt == FW'(FILTER_CNT - 1)) begin
        oPwrGdPsuFilt <= pwrSync[1];
        filtCnt       <= '0;
      end else filtCnt <= filtCnt + 1'b1;
    end
  end
  // Orderly shutdown is checked before the power fall so a coincident SLP_S3# drop disarms
  always_comb begin
    stateNext = state;
    case (state)
      DISARMED:      stateNext = (oPwrGdPsuFilt && slpOk) ? ARMED : DISARMED;
      ARMED:         stateNext = !slpOk ? DISARMED : pwrFall ? EVENT : ARMED;
      EVENT:         stateNext = iFmAdrComplete ? WAIT_ACK : tExpire ? TIMEOUT : EVENT;
      WAIT_ACK:      stateNext = !iFmAdrAck_n ? DONE : tExpire ? TIMEOUT : WAIT_ACK;
      DONE, TIMEOUT: stateNext = slpOk ? state : DISARMED;
      default:       stateNext = DISARMED;
    endcase
    if (!iAdrEna) stateNext = DISARMED;
  end
  always_ff @(posedge iClk) begin
    if (!iRst_n) begin
      state       <= DISARMED;
      tCnt        <= '0;
      oAdrEvent   <= 1'b0;
      oAdrBusy    <= 1'b0;
      oAdrDone    <= 1'b0;
      oAdrTimeout <= 1'b0;
    end else begin
      state       <= stateNext;
      tCnt        <= (stateNext != state || !busyNext) ? '0 :
                     (tCnt == TW'(TIMEOUT_CNT)) ? tCnt : tCnt + 1'b1;
      oAdrEvent   <= busyNext;
      oAdrBusy    <= busyNext;
      oAdrDone    <= stateNext == DONE;
      oAdrTimeout <= stateNext == TIMEOUT;
    end
  end
endmodule
